// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite types and master identifiers for the two-master arbiter
package ahb_pkg;

  localparam int AHB_AW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef logic [2:0] hsize_t;

  typedef struct packed {
    logic [AHB_AW-1:0] addr;
    htrans_t           trans;
    logic              write;
    hsize_t            size;
  } ahb_addr_t;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

endpackage

// File: rtl/ahb_input_stage.sv
// rtl/ahb_input_stage.sv - per-master hold register, source select and HREADY generation
module ahb_input_stage
  import ahb_pkg::*;
(
  input  logic      HCLK,
  input  logic      HRESET,
  input  ahb_addr_t live_addr,
  input  logic      bus_ready,
  input  logic      granted,
  input  logic      dp_mine,
  output logic      req,
  output logic      from_held,
  output ahb_addr_t src,
  output logic      hready
);

  ahb_addr_t held;
  logic      held_valid;
  logic      live;

  // A held entry stalls the master; otherwise only its own data phase can stall it.
  assign hready    = held_valid ? 1'b0 : (dp_mine ? bus_ready : 1'b1);
  assign live      = live_addr.trans[1] & hready;
  assign req       = held_valid | live;
  assign from_held = held_valid;
  assign src       = held_valid ? held : live_addr;

  // granted is only ever asserted while the bus is ready, so !granted covers stalls too.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      held_valid <= 1'b0;
      held       <= '0;
    end else if (live && !granted) begin
      held_valid <= 1'b1;
      held       <= live_addr;
    end else if (held_valid && granted) begin
      held_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - shares one AHB-Lite master port between CPU (M0) and DMA (M1)
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int AW = AHB_AW,
  parameter int DW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [DW-1:0] M0_HWDATA,
  output logic [DW-1:0] M0_HRDATA,
  output logic          M0_HREADY,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [DW-1:0] M1_HWDATA,
  output logic [DW-1:0] M1_HRDATA,
  output logic          M1_HREADY,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY
);

  ahb_addr_t live0, live1, src0, src1, addr_q, dn;
  logic      req0, req1, held0, held1;
  logic      gnt_valid, gnt_id, gnt0, gnt1, contested;
  logic      last_grant, dp_valid, dp_owner;

  assign live0 = '{addr: M0_HADDR, trans: htrans_t'(M0_HTRANS), write: M0_HWRITE, size: M0_HSIZE};
  assign live1 = '{addr: M1_HADDR, trans: htrans_t'(M1_HTRANS), write: M1_HWRITE, size: M1_HSIZE};

  ahb_input_stage u_stage0 (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .live_addr (live0),
    .bus_ready (HREADY),
    .granted   (gnt0),
    .dp_mine   (dp_valid && dp_owner == MST_CPU),
    .req       (req0),
    .from_held (held0),
    .src       (src0),
    .hready    (M0_HREADY)
  );

  ahb_input_stage u_stage1 (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .live_addr (live1),
    .bus_ready (HREADY),
    .granted   (gnt1),
    .dp_mine   (dp_valid && dp_owner == MST_DMA),
    .req       (req1),
    .from_held (held1),
    .src       (src1),
    .hready    (M1_HREADY)
  );

  always_comb begin
    contested = req0 & req1;
    gnt_valid = 1'b0;
    gnt_id    = MST_CPU;
    if (HREADY && (req0 || req1)) begin
      gnt_valid = 1'b1;
      if (contested) begin
        gnt_id = (RR && last_grant == MST_CPU) ? MST_DMA : MST_CPU;
      end else begin
        gnt_id = req1 ? MST_DMA : MST_CPU;
      end
    end
  end

  assign gnt0 = gnt_valid & (gnt_id == MST_CPU);
  assign gnt1 = gnt_valid & (gnt_id == MST_DMA);

  // A replayed entry or an ownership change breaks the burst, so the slave sees a fresh start.
  always_comb begin
    dn       = addr_q;
    dn.trans = IDLE;
    if (gnt_valid) begin
      dn = gnt_id ? src1 : src0;
      if ((gnt_id ? held1 : held0) || gnt_id != dp_owner) begin
        dn.trans = NONSEQ;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_grant <= MST_DMA;
      dp_valid   <= 1'b0;
      dp_owner   <= MST_CPU;
      addr_q     <= '0;
    end else if (HREADY) begin
      dp_valid <= gnt_valid;
      if (gnt_valid) begin
        dp_owner <= gnt_id;
        addr_q   <= dn;
      end
      if (gnt_valid && contested) begin
        last_grant <= gnt_id;
      end
    end
  end

  assign HADDR     = dn.addr;
  assign HTRANS    = dn.trans;
  assign HWRITE    = dn.write;
  assign HSIZE     = dn.size;
  assign HWDATA    = dp_owner ? M1_HWDATA : M0_HWDATA;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed and randomized self-checking bench for ahb_master_arbiter
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam bit RR = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, M0_HREADY, M1_HREADY;
  logic [2:0]  HSIZE;

  xfer_t       drv [2];
  logic [31:0] m_wdata [2];
  logic [31:0] nxt_wdata [2];

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.AW(32), .DW(32), .RR(RR)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .M0_HADDR  (drv[0].addr),
    .M0_HTRANS (drv[0].trans),
    .M0_HWRITE (drv[0].write),
    .M0_HSIZE  (drv[0].size),
    .M0_HWDATA (m_wdata[0]),
    .M0_HRDATA (M0_HRDATA),
    .M0_HREADY (M0_HREADY),
    .M1_HADDR  (drv[1].addr),
    .M1_HTRANS (drv[1].trans),
    .M1_HWRITE (drv[1].write),
    .M1_HSIZE  (drv[1].size),
    .M1_HWDATA (m_wdata[1]),
    .M1_HRDATA (M1_HRDATA),
    .M1_HREADY (M1_HREADY),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_drv(input int m, input logic [31:0] a, input logic [1:0] t, input logic w);
    drv[m].addr  = a;
    drv[m].trans = t;
    drv[m].write = w;
    drv[m].size  = 3'd2;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) set_drv(m, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    HREADY = 1'b1;
    HRDATA = '0;
    idle_all();
    m_wdata[0] = '0;
    m_wdata[1] = '0;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  // Transaction-level model of the shared bus
  xfer_t       pend [2][$];
  xfer_t       mout [2];
  logic        mout_v [2];
  logic        need_new [2];
  logic        seq_ok [2];
  logic [3:0]  last_idx [2];
  logic [31:0] ref_mem [2][16];
  logic [31:0] slv_mem [32];
  logic        dp_act;
  int          dp_own;
  xfer_t       dp_x;
  int          lastg;
  int          prev_own;
  logic [31:0] last_addr;

  task automatic model_init();
    for (int m = 0; m < 2; m++) begin
      pend[m].delete();
      mout_v[m]   = 1'b0;
      need_new[m] = 1'b1;
      seq_ok[m]   = 1'b0;
      last_idx[m] = '0;
      nxt_wdata[m] = '0;
      for (int i = 0; i < 16; i++) ref_mem[m][i] = '0;
    end
    for (int i = 0; i < 32; i++) slv_mem[i] = '0;
    dp_act    = 1'b0;
    dp_own    = 0;
    lastg     = 1;
    prev_own  = 0;
    last_addr = '0;
  endtask

  task automatic pick(input int m, input int pct);
    xfer_t      x;
    logic [3:0] idx;
    x = '{default: '0};
    if ($urandom_range(99) < pct) begin
      if (seq_ok[m] && $urandom_range(1) == 1) begin
        idx     = last_idx[m] + 4'd1;
        x.trans = 2'b11;
      end else begin
        idx     = 4'($urandom_range(15));
        x.trans = 2'b10;
      end
      x.addr      = {25'b0, 1'(m), idx, 2'b00};
      x.write     = 1'($urandom_range(1));
      x.size      = 3'($urandom_range(2));
      x.wdata     = $urandom;
      seq_ok[m]   = 1'b1;
      last_idx[m] = idx;
    end else begin
      seq_ok[m] = 1'b0;
    end
    drv[m] = x;
  endtask

  // Evaluated mid-cycle: checks current outputs, then advances the model across the next edge
  task automatic step();
    logic  hr [2];
    logic  live [2];
    logic  req [2];
    logic  held [2];
    xfer_t src [2];
    logic  gv, contest;
    int    g;
    logic [1:0] et;
    for (int m = 0; m < 2; m++) begin
      held[m] = pend[m].size() != 0;
      hr[m]   = held[m] ? 1'b0 : ((dp_act && dp_own == m) ? HREADY : 1'b1);
      check($sformatf("hready%0d", m), m ? M1_HREADY : M0_HREADY, hr[m]);
      live[m] = drv[m].trans[1] && hr[m];
      src[m]  = held[m] ? pend[m][0] : drv[m];
      req[m]  = held[m] || live[m];
    end
    contest = req[0] && req[1];
    gv      = HREADY && (req[0] || req[1]);
    if (contest) g = RR ? 1 - lastg : 0;
    else         g = req[1] ? 1 : 0;

    if (gv) begin
      et = (held[g] || g != prev_own) ? 2'b10 : src[g].trans;
      check("haddr", HADDR, src[g].addr);
      check("htrans", 32'(HTRANS), 32'(et));
      check("hwrite", 32'(HWRITE), 32'(src[g].write));
      check("hsize", 32'(HSIZE), 32'(src[g].size));
    end else begin
      check("htrans_idle", 32'(HTRANS), 32'h0);
      check("haddr_hold", HADDR, last_addr);
    end

    if (HREADY) begin
      if (dp_act && dp_x.write) begin
        check("hwdata", HWDATA, dp_x.wdata);
        slv_mem[dp_x.addr[6:2]] = HWDATA;
      end
      if (gv) begin
        dp_act    = 1'b1;
        dp_own    = g;
        dp_x      = src[g];
        last_addr = src[g].addr;
        prev_own  = g;
        if (contest) lastg = g;
        if (held[g]) void'(pend[g].pop_front());
      end else begin
        dp_act = 1'b0;
      end
    end

    for (int m = 0; m < 2; m++) begin
      if (live[m] && !(gv && g == m)) pend[m].push_back(drv[m]);
      if (hr[m]) begin
        if (mout_v[m] && !mout[m].write)
          check($sformatf("hrdata%0d", m), m ? M1_HRDATA : M0_HRDATA, mout[m].rexp);
        mout_v[m] = 1'b0;
        if (live[m]) begin
          mout[m]      = drv[m];
          mout[m].rexp = ref_mem[m][drv[m].addr[5:2]];
          if (drv[m].write) ref_mem[m][drv[m].addr[5:2]] = drv[m].wdata;
          mout_v[m]    = 1'b1;
          nxt_wdata[m] = drv[m].wdata;
        end
        need_new[m] = 1'b1;
      end else if (!drv[m].trans[1]) begin
        need_new[m] = 1'b1;
      end
    end
  endtask

  task automatic run_random(input int ncyc, input int pct);
    do_reset();
    model_init();
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        m_wdata[m] = nxt_wdata[m];
        if (need_new[m]) begin
          need_new[m] = 1'b0;
          pick(m, pct);
        end
      end
      HREADY = dp_act ? ($urandom_range(3) != 0) : 1'b1;
      HRDATA = (dp_act && !dp_x.write) ? slv_mem[dp_x.addr[6:2]] : $urandom;
      @(negedge HCLK);
      step();
    end
  endtask

  initial begin
    do_reset();
    @(negedge HCLK);
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_m0_hready", 32'(M0_HREADY), 32'h1);
    check("rst_m1_hready", 32'(M1_HREADY), 32'h1);

    // Solo M0 read, no added latency
    tick();
    set_drv(0, 32'h0000_0010, 2'b10, 1'b0);
    @(negedge HCLK);
    check("solo_haddr", HADDR, 32'h10);
    check("solo_htrans", 32'(HTRANS), 32'h2);
    check("solo_m1_hready", 32'(M1_HREADY), 32'h1);
    tick();
    idle_all();
    HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    check("solo_hrdata", M0_HRDATA, 32'hDEAD_BEEF);
    check("solo_m0_hready", 32'(M0_HREADY), 32'h1);
    check("solo_m1_hready2", 32'(M1_HREADY), 32'h1);

    // Same-cycle contest straight after reset
    do_reset();
    set_drv(0, 32'h0002_0000, 2'b10, 1'b0);
    set_drv(1, 32'h2020_0000, 2'b10, 1'b1);
    @(negedge HCLK);
    check("c2_haddr_m0", HADDR, 32'h0002_0000);
    check("c2_hwrite_m0", 32'(HWRITE), 32'h0);
    tick();
    idle_all();
    m_wdata[1] = 32'h5;
    @(negedge HCLK);
    check("c2_m1_held", 32'(M1_HREADY), 32'h0);
    check("c2_haddr_m1", HADDR, 32'h2020_0000);
    check("c2_htrans_m1", 32'(HTRANS), 32'h2);
    check("c2_hwrite_m1", 32'(HWRITE), 32'h1);
    tick();
    @(negedge HCLK);
    check("c2_hwdata", HWDATA, 32'h5);
    check("c2_m1_hready", 32'(M1_HREADY), 32'h1);

    // Reset with M1 held and M0 stalled in its data phase
    tick();
    set_drv(0, 32'h0000_0100, 2'b10, 1'b0);
    @(negedge HCLK);
    check("r6_haddr", HADDR, 32'h100);
    tick();
    idle_all();
    set_drv(1, 32'h2020_0040, 2'b10, 1'b1);
    HREADY = 1'b0;
    @(negedge HCLK);
    check("r6_m0_stall", 32'(M0_HREADY), 32'h0);
    check("r6_m1_live", 32'(M1_HREADY), 32'h1);
    check("r6_htrans_stall", 32'(HTRANS), 32'h0);
    tick();
    idle_all();
    HRESET = 1'b1;
    @(negedge HCLK);
    check("r6_m1_held", 32'(M1_HREADY), 32'h0);
    tick();
    HRESET = 1'b0;
    HREADY = 1'b1;
    @(negedge HCLK);
    check("r6_htrans", 32'(HTRANS), 32'h0);
    check("r6_m0_hready", 32'(M0_HREADY), 32'h1);
    check("r6_m1_hready", 32'(M1_HREADY), 32'h1);
    tick();
    set_drv(0, 32'h0000_0200, 2'b10, 1'b0);
    set_drv(1, 32'h2020_0080, 2'b10, 1'b1);
    @(negedge HCLK);
    check("r6_first_contest", HADDR, 32'h200);
    tick();
    idle_all();
    @(negedge HCLK);
    check("r6_second", HADDR, 32'h2020_0080);

    run_random(1500, 60);
    run_random(800, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
